ubus_sample_scheduler: RTL and testbench

//  Controller that sequences the ADC121S051 bus-voltage sampler: it issues acquire requests on a

---
 rtl/ubus_sample_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_ubus_sample_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ubus_sample_scheduler.sv
// Acquire/average sequencer for the ADC121S051 Ubus sampler: trigger -> acquire -> done/timeout -> gap.
// Optional over/under-voltage flags on the averaged word when UBUS_LIMIT_EN is defined.
`timescale 1ns/1ps
module ubus_sample_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 400,
    parameter int unsigned MIN_GAP        = 8,
    parameter int unsigned AVG_LOG2       = 2
`ifdef UBUS_LIMIT_EN
    ,
    parameter logic [11:0] OV_LIMIT = 12'd3900,
    parameter logic [11:0] UV_LIMIT = 12'd500
`endif
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iEnable,
    input  logic        iTrig,
    input  logic        iErr_clr,
    output logic        oAcquire_en,
    input  logic        iAcquire_done,
    input  logic [11:0] iUbus,
    output logic [11:0] oUbus_avg,
    output logic        oValid,
    output logic        oBusy,
    output logic        oTimeout_err,
    output logic        oOverrun
`ifdef UBUS_LIMIT_EN
    ,
    output logic        oOv,
    output logic        oUv
`endif
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned GW = $clog2(MIN_GAP);
    localparam int unsigned CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned AW = 12 + AVG_LOG2;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
    // START adds one more low cycle, so GAP itself lasts MIN_GAP-1 cycles.
    localparam logic [GW-1:0] GAP_LAST  = GW'(MIN_GAP - 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'((32'd1 << AVG_LOG2) - 32'd1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [11:0]   avg_q, avg_d;
    logic          done_q, done_prev_q;
    logic          cap_q, cap_d;
    logic          valid_q, valid_d;
    logic          pend_q, pend_d;
    logic          acq_q, acq_d;
    logic          tmo_q, tmo_d;
    logic          ovr_q, ovr_d;
`ifdef UBUS_LIMIT_EN
    logic          ov_q, ov_d;
    logic          uv_q, uv_d;
`endif

    logic          done_rise, trig_en, gap_exit, tmo_evt, ovr_evt;
    logic [AW-1:0] sum;

    assign done_rise = done_q & ~done_prev_q;
    assign trig_en   = iTrig & iEnable;
    assign gap_exit  = (state_q == S_GAP) && (gcnt_q == GAP_LAST);
    assign sum       = acc_q + AW'(iUbus);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        avg_d   = avg_q;
        cap_d   = 1'b0;
        valid_d = 1'b0;
        pend_d  = pend_q;
        tmo_evt = 1'b0;
        ovr_evt = 1'b0;
`ifdef UBUS_LIMIT_EN
        ov_d    = ov_q;
        uv_d    = uv_q;
`endif

        case (state_q)
            S_IDLE: begin
                wcnt_d = '0;
                gcnt_d = '0;
                pend_d = 1'b0;
                if (!iEnable) begin
                    acc_d = '0;
                    cnt_d = '0;
                end
                if (trig_en) state_d = S_START;
            end
            S_START: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    cap_d   = 1'b1;
                    gcnt_d  = '0;
                    state_d = S_GAP;
                end else if (wcnt_q == WAIT_LAST) begin
                    tmo_evt = 1'b1;
                    gcnt_d  = '0;
                    state_d = S_GAP;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_exit) begin
                    state_d = ((pend_q | trig_en) && iEnable) ? S_START : S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // One-deep trigger queue; at GAP exit the slot is consumed and a same-cycle trigger refills it.
        if (state_q != S_IDLE) begin
            if (!iEnable) begin
                pend_d = 1'b0;
            end else if (gap_exit) begin
                pend_d = pend_q & iTrig;
            end else if (iTrig) begin
                if (pend_q) ovr_evt = 1'b1;
                else        pend_d  = 1'b1;
            end
        end

        if (cap_q) begin
            if (cnt_q == CNT_LAST) begin
                avg_d   = sum[AW-1:AVG_LOG2];
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
`ifdef UBUS_LIMIT_EN
                ov_d    = (sum[AW-1:AVG_LOG2] > OV_LIMIT);
                uv_d    = (sum[AW-1:AVG_LOG2] < UV_LIMIT);
`endif
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end

        tmo_d = (tmo_q & ~iErr_clr) | tmo_evt;
        ovr_d = (ovr_q & ~iErr_clr) | ovr_evt;
        acq_d = (state_d == S_WAIT);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            gcnt_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            avg_q       <= '0;
            done_q      <= 1'b0;
            done_prev_q <= 1'b0;
            cap_q       <= 1'b0;
            valid_q     <= 1'b0;
            pend_q      <= 1'b0;
            acq_q       <= 1'b0;
            tmo_q       <= 1'b0;
            ovr_q       <= 1'b0;
`ifdef UBUS_LIMIT_EN
            ov_q        <= 1'b0;
            uv_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            gcnt_q      <= gcnt_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            avg_q       <= avg_d;
            done_q      <= iAcquire_done;
            done_prev_q <= done_q;
            cap_q       <= cap_d;
            valid_q     <= valid_d;
            pend_q      <= pend_d;
            acq_q       <= acq_d;
            tmo_q       <= tmo_d;
            ovr_q       <= ovr_d;
`ifdef UBUS_LIMIT_EN
            ov_q        <= ov_d;
            uv_q        <= uv_d;
`endif
        end
    end

    assign oAcquire_en  = acq_q;
    assign oUbus_avg    = avg_q;
    assign oValid       = valid_q;
    assign oBusy        = (state_q != S_IDLE);
    assign oTimeout_err = tmo_q;
    assign oOverrun     = ovr_q;
`ifdef UBUS_LIMIT_EN
    assign oOv          = ov_q;
    assign oUv          = uv_q;
`endif

endmodule

// File: tb/tb_ubus_sample_scheduler.sv
// Directed bench for ubus_sample_scheduler with a behavioural ADC core model.
`timescale 1ns/1ps
module tb_ubus_sample_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        trig = 1'b0;
    logic        clr = 1'b0;
    logic        done;
    logic [11:0] ubus;
    logic        acq, valid, busy, tmo, ovr;
    logic [11:0] avg;
`ifdef UBUS_LIMIT_EN
    logic        ov, uv;
`endif

    always #5 clk = ~clk;

    ubus_sample_scheduler #(
        .TIMEOUT_CYCLES(400),
        .MIN_GAP(8),
        .AVG_LOG2(2)
    ) dut (
        .iClk(clk),
        .iRst_n(rst_n),
        .iEnable(en),
        .iTrig(trig),
        .iErr_clr(clr),
        .oAcquire_en(acq),
        .iAcquire_done(done),
        .iUbus(ubus),
        .oUbus_avg(avg),
        .oValid(valid),
        .oBusy(busy),
        .oTimeout_err(tmo),
        .oOverrun(ovr)
`ifdef UBUS_LIMIT_EN
        ,
        .oOv(ov),
        .oUv(uv)
`endif
    );

    // ADC core model: answers LAT cycles after the acquire edge, tracks acquire high/low widths.
    logic        respond = 1'b1;
    int          lat = 320;
    logic [11:0] next_sample = 12'h000;
    logic        acq_prev;
    int          dcnt, conv_cnt, valid_cnt, hi_len, last_hi, lo_len, last_lo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            ubus      <= 12'h000;
            acq_prev  <= 1'b0;
            dcnt      <= 0;
            conv_cnt  <= 0;
            valid_cnt <= 0;
            hi_len    <= 0;
            last_hi   <= 0;
            lo_len    <= 0;
            last_lo   <= 0;
        end else begin
            acq_prev <= acq;
            if (acq && !acq_prev) begin
                conv_cnt <= conv_cnt + 1;
                dcnt     <= 1;
                last_lo  <= lo_len;
                hi_len   <= 1;
            end else if (acq) begin
                hi_len <= hi_len + 1;
            end
            if (!acq && acq_prev) begin
                last_hi <= hi_len;
                lo_len  <= 1;
            end else if (!acq) begin
                lo_len <= lo_len + 1;
            end
            if (dcnt != 0) begin
                if (dcnt == lat) begin
                    dcnt <= 0;
                    if (respond) begin
                        done <= 1'b1;
                        ubus <= next_sample;
                    end
                end else begin
                    dcnt <= dcnt + 1;
                end
            end
            if (!acq) done <= 1'b0;
            if (valid) valid_cnt <= valid_cnt + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_acq(input string tag);
        int n = 0;
        while (!acq && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(acq), 32'd1);
    endtask

    task automatic conv(input logic [11:0] s);
        next_sample = s;
        pulse_trig();
        wait_idle("conv_idle");
    endtask

    int v0, c0;

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("rst_acq", 32'(acq), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_avg", 32'(avg), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);

        en = 1'b1;
        next_sample = 12'h800;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_acq_low", 32'(acq), 32'd0);
        @(negedge clk);
        check("acq_at_t2", 32'(acq), 32'd1);

        tick(20);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_acq", 32'(acq), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        check("async_rst_avg", 32'(avg), 32'd0);

        for (int i = 0; i < 4; i++) begin
            conv(12'h800);
            if (i == 2) check("t1_no_early_valid", 32'(valid_cnt), 32'd0);
        end
        check("t1_valid_cnt", 32'(valid_cnt), 32'd1);
        check("t1_avg", 32'(avg), 32'h800);

        v0 = valid_cnt;
        conv(12'd100);
        conv(12'd101);
        conv(12'd102);
        check("t2_no_early_valid", 32'(valid_cnt), 32'(v0));
        check("t2_avg_held", 32'(avg), 32'h800);
        conv(12'd104);
        check("t2_valid_cnt", 32'(valid_cnt), 32'(v0 + 1));
        check("t2_avg", 32'(avg), 32'd101);

        respond = 1'b0;
        v0 = valid_cnt;
        pulse_trig();
        wait_idle("t3_idle");
        check("t3_acq_width", 32'(last_hi), 32'd400);
        check("t3_tmo", 32'(tmo), 32'd1);
        check("t3_no_valid", 32'(valid_cnt), 32'(v0));
        check("t3_avg_kept", 32'(avg), 32'd101);
        pulse_clr();
        check("t3_tmo_clr", 32'(tmo), 32'd0);
        respond = 1'b1;

        c0 = conv_cnt;
        next_sample = 12'h100;
        pulse_trig();
        wait_acq("t4_acq");
        tick(5);
        pulse_trig();
        tick(3);
        check("t4_no_ovr_yet", 32'(ovr), 32'd0);
        pulse_trig();
        tick(3);
        pulse_trig();
        check("t4_ovr", 32'(ovr), 32'd1);
        wait_idle("t4_idle");
        check("t4_conv_cnt", 32'(conv_cnt), 32'(c0 + 2));
        check("t4_gap_len", 32'(last_lo), 32'd8);
        check("t4_ovr_sticky", 32'(ovr), 32'd1);
        pulse_clr();
        check("t4_ovr_clr", 32'(ovr), 32'd0);

        c0 = conv_cnt;
        v0 = valid_cnt;
        next_sample = 12'h100;
        pulse_trig();
        wait_acq("t5_acq");
        tick(5);
        pulse_trig();
        tick(5);
        en = 1'b0;
        wait_idle("t5_idle");
        tick(30);
        check("t5_conv_cnt", 32'(conv_cnt), 32'(c0 + 1));
        check("t5_no_valid", 32'(valid_cnt), 32'(v0));
        pulse_trig();
        check("t5_trig_ignored", 32'(busy), 32'd0);
        en = 1'b1;
        conv(12'd200);
        conv(12'd200);
        conv(12'd200);
        check("t5_acc_cleared", 32'(valid_cnt), 32'(v0));
        conv(12'd203);
        check("t5_valid_cnt", 32'(valid_cnt), 32'(v0 + 1));
        check("t5_avg", 32'(avg), 32'd200);

`ifdef UBUS_LIMIT_EN
        for (int i = 0; i < 4; i++) conv(12'd3950);
        check("t6_avg_hi", 32'(avg), 32'd3950);
        check("t6_ov_hi", 32'(ov), 32'd1);
        check("t6_uv_hi", 32'(uv), 32'd0);
        for (int i = 0; i < 4; i++) conv(12'd400);
        check("t6_ov_lo", 32'(ov), 32'd0);
        check("t6_uv_lo", 32'(uv), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
